// File: rtl/sdf_bitrev_reorder_pkg.sv
// sdf_bitrev_reorder_pkg: shared widths, sample type, read-FSM states and bit-reverse helper
package sdf_bitrev_reorder_pkg;
  localparam int DEF_INTEGER_SIZE = 8;
  localparam int DEF_FRACT_SIZE = 8;
  localparam int DATA_WIDTH = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;
  localparam int DEF_NFFT = 128;
  localparam int ADDR_W = $clog2(DEF_NFFT);
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } cpx_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
    bitrev = '0;
    for (int i = 0; i < 16; i++)
      if (i < w) bitrev[i] = v[w-1-i];
  endfunction
endpackage

// File: rtl/sdf_bitrev_reorder_bank_ram.sv
// sdf_bitrev_reorder_bank_ram: two-bank simple dual-port RAM, address = {bank, index}
module sdf_bitrev_reorder_bank_ram
  import sdf_bitrev_reorder_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_WIDTH,
  parameter int AW = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sdf_bitrev_reorder.sv
// sdf_bitrev_reorder: ping-pong buffer turning bit-reversed SDF FFT frames into natural order
module sdf_bitrev_reorder
  import sdf_bitrev_reorder_pkg::*;
#(
  parameter int INTEGER_SIZE = DEF_INTEGER_SIZE,
  parameter int FRACT_SIZE = DEF_FRACT_SIZE,
  parameter int NFFT = DEF_NFFT,
  localparam int DW = INTEGER_SIZE + FRACT_SIZE,
  localparam int AW = $clog2(NFFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [AW-1:0]        out_index,
  output logic                 out_last
);
  logic [AW-1:0] wcnt, rcnt, p_index, wrev;
  logic wbank, rbank, p_valid, p_last;
  logic [1:0] full;
  logic [2*DW-1:0] rdata;
  logic accept, w_done, load, p_adv, issue, r_done;
  rd_state_t state, state_nx;
  assign in_ready = ~full[wbank];
  assign accept = in_valid & in_ready;
  assign w_done = accept & (wcnt == AW'(NFFT - 1));
  assign wrev = AW'(bitrev(16'(wcnt), AW));
  // The RAM read result sits in a one-deep stage (p_*) ahead of the output register.
  assign load = ~out_valid | out_ready;
  assign p_adv = ~p_valid | load;
  always_comb begin
    issue = p_adv & ((state == RD_STREAM) | full[rbank]);
    r_done = issue & (rcnt == AW'(NFFT - 1));
    state_nx = (state == RD_IDLE) ? (full[rbank] ? RD_STREAM : RD_IDLE)
                                  : ((r_done & ~full[~rbank]) ? RD_IDLE : RD_STREAM);
  end
  sdf_bitrev_reorder_bank_ram #(.WIDTH(2 * DW), .AW(AW + 1)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({wbank, wrev}),
    .wdata ({in_r, in_i}),
    .re    (issue),
    .raddr ({rbank, rcnt}),
    .rdata (rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RD_IDLE;
      wcnt <= '0;
      wbank <= 1'b0;
      rcnt <= '0;
      rbank <= 1'b0;
      full <= '0;
      p_valid <= 1'b0;
      p_index <= '0;
      p_last <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_index <= '0;
      out_r <= '0;
      out_i <= '0;
    end else begin
      state <= state_nx;
      full <= (full | ({1'b0, w_done} << wbank)) & ~({1'b0, r_done} << rbank);
      if (accept) begin
        wcnt <= wcnt + 1'b1;
        wbank <= wbank ^ w_done;
      end
      if (issue) begin
        rcnt <= rcnt + 1'b1;
        rbank <= rbank ^ r_done;
        p_index <= rcnt;
        p_last <= r_done;
      end
      if (p_adv) p_valid <= issue;
      if (load) out_valid <= p_valid;
      if (load & p_valid) begin
        out_r <= rdata[2*DW-1:DW];
        out_i <= rdata[DW-1:0];
        out_index <= p_index;
        out_last <= p_last;
      end
    end
  end
endmodule
